// File: rtl/sram_word_ctrl_pkg.sv
// Shared definitions for the SRAM word controller.
//  - Word-level and byte-level FSM state encodings.
//  - BYTES_PER_WORD and the strobe-counter width, which is sized for the
//    largest legal STROBE_CYC.
//  - Helpers that pick and replace one byte of a 32-bit word. Byte 0 is the
//    most significant byte, so words are stored big-endian.
package sram_word_ctrl_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int STROBE_CYC_MAX = 15;
  localparam int STROBE_CNT_W   = $clog2(STROBE_CYC_MAX + 1);

  typedef enum logic [1:0] {
    W_IDLE,
    W_BUSY,
    W_DONE
  } word_state_t;

  typedef enum logic [1:0] {
    B_IDLE,
    B_SETUP,
    B_STROBE,
    B_HOLD
  } byte_state_t;

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] k);
    return w[(BYTES_PER_WORD - 1 - int'(k)) * 8 +: 8];
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] k,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[(BYTES_PER_WORD - 1 - int'(k)) * 8 +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/sram_word_ctrl_if.sv
// Request/response bus between the SHA-256 datapath and sram_word_ctrl.
//  req_valid/req_ready : request handshake, accepted when both are high
//  req_we              : 1 = write word, 0 = read word
//  req_addr            : word address (ADDR_W-2 bits)
//  req_wdata           : write word, byte 0 in bits [31:24]
//  rsp_valid           : one-cycle completion pulse for reads and writes
//  rsp_rdata           : read word, valid with rsp_valid on reads
// The master modport is the datapath side; the slave modport is the controller.
interface sram_word_ctrl_if #(
  parameter int ADDR_W = 15
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-3:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/sram_byte_cycle.sv
// Runs one SRAM byte access: SETUP -> STROBE (STROBE_CYC cycles) -> HOLD.
//  clk, rst_n : clock and asynchronous active-low reset
//  start      : begin a byte; honoured in idle or in HOLD, which chains the
//               next byte with no gap cycle
//  is_write   : access direction for the byte being started
//  addr_in    : byte address for the byte being started
//  wr_in      : write data for the byte being started
//  io_in      : SRAM data bus as seen at the pins
//  done       : high during HOLD, the last cycle of the byte
//  rd_byte    : byte captured at the edge that ends the last STROBE cycle
//  a, cs, oe, we, drv_en, wr_byte : pin-facing outputs, all straight from flops
// Pin flops are loaded from the next state, so each strobe changes exactly
// at the edge that enters or leaves the corresponding state.
module sram_byte_cycle
  import sram_word_ctrl_pkg::*;
#(
  parameter int STROBE_CYC = 2,
  parameter int ADDR_W     = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_write,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [7:0]        wr_in,
  input  logic [7:0]        io_in,
  output logic              done,
  output logic [7:0]        rd_byte,
  output logic [ADDR_W-1:0] a,
  output logic              cs,
  output logic              oe,
  output logic              we,
  output logic              drv_en,
  output logic [7:0]        wr_byte
);

  localparam logic [STROBE_CNT_W-1:0] LAST_CNT = STROBE_CNT_W'(STROBE_CYC - 1);

  if (STROBE_CYC < 1 || STROBE_CYC > STROBE_CYC_MAX) begin : g_bad_strobe
    $error("STROBE_CYC must be in 1..15");
  end

  byte_state_t             state;
  byte_state_t             nxt;
  logic [STROBE_CNT_W-1:0] cnt;
  logic                    wr_mode_q;
  logic                    take;
  logic                    mode_nxt;
  logic                    active_nxt;

  // A start outside idle/HOLD would corrupt a byte in flight, so it is ignored.
  assign take       = start && ((state == B_IDLE) || (state == B_HOLD));
  assign mode_nxt   = take ? is_write : wr_mode_q;
  assign active_nxt = (nxt != B_IDLE);
  assign done       = (state == B_HOLD);

  always_comb begin
    nxt = state;
    case (state)
      B_IDLE:   if (take) nxt = B_SETUP;
      B_SETUP:  nxt = B_STROBE;
      B_STROBE: if (cnt == LAST_CNT) nxt = B_HOLD;
      B_HOLD:   nxt = take ? B_SETUP : B_IDLE;
      default:  nxt = B_IDLE;
    endcase
  end

  // Control and pin flops: reset forces strobes high and releases the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= B_IDLE;
      cnt       <= '0;
      wr_mode_q <= 1'b0;
      a         <= '0;
      cs        <= 1'b1;
      oe        <= 1'b1;
      we        <= 1'b1;
      drv_en    <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= ((state == B_STROBE) && (nxt == B_STROBE)) ? cnt + 1'b1 : '0;
      if (take) begin
        wr_mode_q <= is_write;
        a         <= addr_in;
      end
      cs     <= !active_nxt;
      oe     <= !((nxt == B_STROBE) && !mode_nxt);
      we     <= !((nxt == B_STROBE) && mode_nxt);
      // Writes drive through SETUP, STROBE and HOLD; the bus is released
      // at the same edge CS rises.
      drv_en <= active_nxt && mode_nxt;
    end
  end

  // Data flops.
  always_ff @(posedge clk) begin
    if (take) wr_byte <= wr_in;
    if ((state == B_STROBE) && (cnt == LAST_CNT) && !wr_mode_q) rd_byte <= io_in;
  end

endmodule

// File: rtl/sram_word_ctrl.sv
// Word-level initiator for a 32Kx8 asynchronous SRAM.
//  clk, rst_n : clock and asynchronous active-low reset
//  bus        : sram_word_ctrl_if slave port (request handshake and response)
//  a          : SRAM byte address, {word address, byte index}
//  io         : shared 8-bit SRAM data bus, driven only during write bytes
//  cs, oe, we : active-low SRAM strobes, registered
// Each word is four chained byte cycles (byte 0 first, most significant byte),
// followed by one DONE cycle carrying the rsp_valid pulse. Read bytes are
// assembled in a side register and only copied to rsp_rdata when the whole
// word is in, so an aborted read never exposes a partial word.
module sram_word_ctrl
  import sram_word_ctrl_pkg::*;
#(
  parameter int STROBE_CYC = 2,
  parameter int ADDR_W     = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_word_ctrl_if.slave   bus,
  output logic [ADDR_W-1:0] a,
  inout  wire  [7:0]        io,
  output logic              cs,
  output logic              oe,
  output logic              we
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  word_state_t       state;
  word_state_t       nxt;
  logic              accept;
  logic              start;
  logic              byte_done;
  logic              last_byte;
  logic              word_end;
  logic              start_we;
  logic [1:0]        k_q;
  logic [ADDR_W-3:0] addr_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic [31:0]       rd_word_q;
  logic [31:0]       rd_word_nxt;
  logic [ADDR_W-1:0] start_addr;
  logic [7:0]        start_byte;
  logic [7:0]        wr_byte;
  logic [7:0]        rd_byte;
  logic              drv_en;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;

  assign accept    = (state == W_IDLE) && bus.req_valid;
  assign last_byte = (k_q == LAST_BYTE);
  assign word_end  = (state == W_BUSY) && byte_done && last_byte;
  assign start     = accept || ((state == W_BUSY) && byte_done && !last_byte);

  // The first byte comes straight from the request; later bytes from the
  // latched copy, one index ahead of the byte now in HOLD.
  assign start_addr = accept ? {bus.req_addr, 2'b00} : {addr_q, k_q + 2'd1};
  assign start_byte = accept ? word_byte(bus.req_wdata, 2'd0) : word_byte(wdata_q, k_q + 2'd1);
  assign start_we   = accept ? bus.req_we : we_q;

  assign rd_word_nxt = put_byte(rd_word_q, k_q, rd_byte);

  assign bus.req_ready = (state == W_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  assign io = drv_en ? wr_byte : 8'bz;

  sram_byte_cycle #(
    .STROBE_CYC (STROBE_CYC),
    .ADDR_W     (ADDR_W)
  ) u_byte (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .is_write (start_we),
    .addr_in  (start_addr),
    .wr_in    (start_byte),
    .io_in    (io),
    .done     (byte_done),
    .rd_byte  (rd_byte),
    .a        (a),
    .cs       (cs),
    .oe       (oe),
    .we       (we),
    .drv_en   (drv_en),
    .wr_byte  (wr_byte)
  );

  always_comb begin
    nxt = state;
    case (state)
      W_IDLE:  if (accept) nxt = W_BUSY;
      W_BUSY:  if (word_end) nxt = W_DONE;
      W_DONE:  nxt = W_IDLE;
      default: nxt = W_IDLE;
    endcase
  end

  // Control flops: state, byte index and response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= W_IDLE;
      k_q         <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state <= nxt;
      if (accept) k_q <= 2'd0;
      else if ((state == W_BUSY) && byte_done) k_q <= k_q + 2'd1;
      rsp_valid_q <= word_end;
      // Write acks leave rsp_rdata untouched.
      if (word_end && !we_q) rsp_rdata_q <= rd_word_nxt;
    end
  end

  // Request capture and read-word assembly.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      we_q    <= bus.req_we;
    end
    if ((state == W_BUSY) && byte_done) rd_word_q <= rd_word_nxt;
  end

  a_no_oe_we_overlap: assert property (@(posedge clk) disable iff (!rst_n) (oe || we));
  a_no_drive_on_read: assert property (@(posedge clk) disable iff (!rst_n) !(drv_en && !oe));
  a_release_by_cs:    assert property (@(posedge clk) disable iff (!rst_n) (cs |-> !drv_en));
  a_turnaround:       assert property (@(posedge clk) disable iff (!rst_n) (!oe |-> !$past(drv_en)));

endmodule
